// File: rtl/rob_controller.sv
// In-order reorder-buffer controller: allocation at tail, CDB writeback by tag,
// in-order retirement from head through a valid/ready handshake.
module rob_controller #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [3:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              lookup_ready,
  output logic [DATA_W-1:0] lookup_value,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [3:0]        commit_func,
  output logic [3:0]        commit_rd,
  output logic [DATA_W-1:0] commit_value,
  input  logic              commit_ready,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              wb_err
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head_q,  head_d;
  logic [TAG_W-1:0]  tail_q,  tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              wb_err_q, wb_err_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [3:0]        func_q  [DEPTH];
  logic [3:0]        func_d  [DEPTH];
  logic [3:0]        rd_q    [DEPTH];
  logic [3:0]        rd_d    [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];

  logic alloc_fire;
  logic commit_fire;
  logic wb_legal;
  logic head_live;
  logic lookup_hit;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign wb_err      = wb_err_q;

  assign head_live    = valid_q[head_q];
  assign commit_valid = valid_q[head_q] && ready_q[head_q];
  assign commit_tag   = head_q;
  assign commit_func  = head_live ? func_q[head_q]  : '0;
  assign commit_rd    = head_live ? rd_q[head_q]    : '0;
  assign commit_value = head_live ? value_q[head_q] : '0;

  assign lookup_hit   = wb_valid && (wb_tag == lookup_tag);
  assign lookup_ready = valid_q[lookup_tag] && (ready_q[lookup_tag] || lookup_hit);
  assign lookup_value = !valid_q[lookup_tag] ? '0 :
                        lookup_hit           ? wb_value : value_q[lookup_tag];

  assign alloc_fire  = alloc_valid && !full;
  assign commit_fire = commit_valid && commit_ready;
  assign wb_legal    = valid_q[wb_tag] && !ready_q[wb_tag];

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wb_err_d = wb_err_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    func_d   = func_q;
    rd_d     = rd_q;
    value_d  = value_q;

    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      wb_err_d = 1'b0;
      valid_d  = '0;
      ready_d  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        func_d[i]  = '0;
        rd_d[i]    = '0;
        value_d[i] = '0;
      end
    end else begin
      // Head and tail only coincide when empty (no commit) or full (no
      // alloc), and a committing head is already ready so a writeback to it
      // is illegal; the three updates below therefore never collide.
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        func_d[head_q]  = '0;
        rd_d[head_q]    = '0;
        value_d[head_q] = '0;
        head_d          = head_q + TAG_W'(1);
      end

      if (wb_valid) begin
        if (wb_legal) begin
          value_d[wb_tag] = wb_value;
          ready_d[wb_tag] = 1'b1;
        end else begin
          wb_err_d = 1'b1;
        end
      end

      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        func_d[tail_q]  = alloc_func;
        rd_d[tail_q]    = alloc_rd;
        value_d[tail_q] = '0;
        tail_d          = tail_q + TAG_W'(1);
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
      valid_q  <= '0;
      ready_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        func_q[i]  <= '0;
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wb_err_q <= wb_err_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      func_q   <= func_d;
      rd_q     <= rd_d;
      value_q  <= value_d;
    end
  end

endmodule

// File: tb/tb_rob_controller.sv
module tb_rob_controller;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic [3:0]  alloc_func;
  logic [3:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [15:0] wb_value;
  logic [2:0]  lookup_tag;
  logic        lookup_ready;
  logic [15:0] lookup_value;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic [3:0]  commit_func;
  logic [3:0]  commit_rd;
  logic [15:0] commit_value;
  logic        commit_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        wb_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk1 = ~clk1;

  rob_controller #(.DEPTH(8), .TAG_W(3), .DATA_W(16)) dut (
    .clk1(clk1), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .lookup_tag(lookup_tag), .lookup_ready(lookup_ready), .lookup_value(lookup_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_func(commit_func),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_ready(commit_ready),
    .count(count), .full(full), .empty(empty), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wb(input logic [2:0] t, input logic [15:0] v);
    wb_valid = 1'b1;
    wb_tag   = t;
    wb_value = v;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_value = '0;
    lookup_tag = '0; commit_ready = 1'b0;
    repeat (2) tick();
    check("rst_alloc_ready", 32'(alloc_ready), 1);
    check("rst_alloc_tag",   32'(alloc_tag), 0);
    check("rst_empty",       32'(empty), 1);
    check("rst_full",        32'(full), 0);
    check("rst_commit_valid",32'(commit_valid), 0);
    check("rst_lookup_ready",32'(lookup_ready), 0);
    check("rst_count",       32'(count), 0);
    check("rst_wb_err",      32'(wb_err), 0);
    rst = 1'b0;
    tick();

    // three allocations, rd = 1,2,3, func = 4,5,6
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 4'(i + 1);
      alloc_func  = 4'(i + 4);
      #1;
      check("alloc_tag_seq", 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    check("count3", 32'(count), 3);
    check("no_commit_yet", 32'(commit_valid), 0);

    // out-of-order writeback, in-order commit
    wb(3'd1, 16'h00AA);
    #1;
    check("cv_after_tag1", 32'(commit_valid), 0);
    wb(3'd0, 16'h0055);
    #1;
    check("cv_after_tag0", 32'(commit_valid), 1);
    check("c0_tag",   32'(commit_tag), 0);
    check("c0_rd",    32'(commit_rd), 1);
    check("c0_func",  32'(commit_func), 4);
    check("c0_value", 32'(commit_value), 32'h55);
    commit_ready = 1'b1;
    tick();
    check("c1_valid", 32'(commit_valid), 1);
    check("c1_tag",   32'(commit_tag), 1);
    check("c1_rd",    32'(commit_rd), 2);
    check("c1_value", 32'(commit_value), 32'hAA);
    tick();
    commit_ready = 1'b0;
    #1;
    check("c2_not_ready", 32'(commit_valid), 0);
    check("count1",       32'(count), 1);
    check("head2",        32'(commit_tag), 2);

    // fill from a clean ROB
    do_flush();
    check("flush_count", 32'(count), 0);
    for (int k = 0; k < 8; k++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 4'(k);
      alloc_func  = 4'(k + 1);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    check("full",            32'(full), 1);
    check("full_alloc_ready",32'(alloc_ready), 0);
    check("full_count",      32'(count), 8);
    check("full_tail_wrap",  32'(alloc_tag), 0);
    wb(3'd0, 16'h0100);
    alloc_valid  = 1'b1;
    alloc_rd     = 4'hF;
    alloc_func   = 4'hE;
    commit_ready = 1'b1;
    #1;
    check("full_cv", 32'(commit_valid), 1);
    tick();
    commit_ready = 1'b0;
    #1;
    check("refused_count",       32'(count), 7);
    check("refused_head",        32'(commit_tag), 1);
    check("refused_alloc_ready", 32'(alloc_ready), 1);
    check("refused_alloc_tag",   32'(alloc_tag), 0);
    tick();
    alloc_valid = 1'b0;
    #1;
    check("retry_count", 32'(count), 8);
    check("retry_tail",  32'(alloc_tag), 1);
    check("retry_full",  32'(full), 1);

    // stall with head ready; writebacks to other tags meanwhile
    wb(3'd1, 16'h0111);
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin wb_valid = 1'b1; wb_tag = 3'd2; wb_value = 16'h0222; end
      if (c == 1) begin wb_valid = 1'b1; wb_tag = 3'd3; wb_value = 16'h0333; end
      #1;
      check("stall_cv",    32'(commit_valid), 1);
      check("stall_tag",   32'(commit_tag), 1);
      check("stall_rd",    32'(commit_rd), 1);
      check("stall_value", 32'(commit_value), 32'h111);
      tick();
      wb_valid = 1'b0;
    end
    check("stall_err", 32'(wb_err), 0);
    commit_ready = 1'b1;
    #1;
    check("rel1_value", 32'(commit_value), 32'h111);
    tick();
    check("rel2_tag",   32'(commit_tag), 2);
    check("rel2_value", 32'(commit_value), 32'h222);
    tick();
    check("rel3_tag",   32'(commit_tag), 3);
    check("rel3_value", 32'(commit_value), 32'h333);
    tick();
    commit_ready = 1'b0;
    #1;
    check("rel_done_cv",   32'(commit_valid), 0);
    check("rel_done_cnt",  32'(count), 5);

    // illegal writebacks
    do_flush();
    check("fl_empty", 32'(empty), 1);
    check("fl_err",   32'(wb_err), 0);
    wb(3'd5, 16'h0005);
    lookup_tag = 3'd5;
    #1;
    check("wb_empty_err", 32'(wb_err), 1);
    check("wb_empty_lr",  32'(lookup_ready), 0);
    check("wb_empty_lv",  32'(lookup_value), 0);
    check("wb_empty_cnt", 32'(count), 0);
    do_flush();
    check("err_cleared", 32'(wb_err), 0);
    alloc_valid = 1'b1; alloc_rd = 4'd9; alloc_func = 4'd3;
    tick();
    alloc_valid = 1'b0;
    wb(3'd0, 16'h0077);
    check("wb_ok_err", 32'(wb_err), 0);
    wb(3'd0, 16'h0099);
    check("dup_err",   32'(wb_err), 1);
    check("dup_value", 32'(commit_value), 32'h77);
    check("dup_cv",    32'(commit_valid), 1);
    do_flush();
    alloc_valid = 1'b1; alloc_rd = 4'd4;
    wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 16'h0044;
    tick();
    alloc_valid = 1'b0; wb_valid = 1'b0;
    #1;
    check("samecyc_err",   32'(wb_err), 1);
    check("samecyc_count", 32'(count), 1);
    check("samecyc_cv",    32'(commit_valid), 0);
    do_flush();
    check("fl2_count", 32'(count), 0);
    check("fl2_err",   32'(wb_err), 0);
    check("fl2_cv",    32'(commit_valid), 0);

    // lookup forwarding
    alloc_valid = 1'b1;
    repeat (3) tick();
    alloc_valid = 1'b0;
    lookup_tag = 3'd2;
    wb_valid = 1'b1; wb_tag = 3'd2; wb_value = 16'h1234;
    #1;
    check("fwd_ready", 32'(lookup_ready), 1);
    check("fwd_value", 32'(lookup_value), 32'h1234);
    tick();
    wb_valid = 1'b0;
    #1;
    check("stored_ready", 32'(lookup_ready), 1);
    check("stored_value", 32'(lookup_value), 32'h1234);
    lookup_tag = 3'd1;
    #1;
    check("pend_ready", 32'(lookup_ready), 0);
    check("pend_value", 32'(lookup_value), 0);
    lookup_tag = 3'd5;
    wb_valid = 1'b1; wb_tag = 3'd5; wb_value = 16'hBEEF;
    #1;
    check("inv_ready", 32'(lookup_ready), 0);
    check("inv_value", 32'(lookup_value), 0);
    wb_valid = 1'b0;

    // asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    check("arst_empty", 32'(empty), 1);
    check("arst_count", 32'(count), 0);
    check("arst_tag",   32'(alloc_tag), 0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
